// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared arithmetic-unit constants and divider state encoding
package arith_pkg;

    // Default operand width shared by the multiplier and the divider
    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // Shift the next dividend bit into the remainder and trial-subtract the
    // divisor one bit wider than the operands so the borrow survives.
    // rem is always below the divisor (<= 2^(WIDTH-1)), so its top bit is
    // zero and the shifted value never overflows WIDTH+1 bits.
    always_comb begin
        trial    = {rem, dvd_bit} - {1'b0, divisor};
        q_bit    = ~trial[WIDTH];
        rem_next = trial[WIDTH] ? {rem[WIDTH-2:0], dvd_bit} : trial[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - iterative signed divider, one restoring step per clock
module seq_signed_divider
    import arith_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;
    logic             dz;
    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Magnitudes; the most-negative value maps to 2^(WIDTH-1), which still
    // fits an unsigned WIDTH-bit field.
    assign a_mag = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign b_mag = B[WIDTH-1] ? (~B + 1'b1) : B;
    assign busy  = (state != DIV_IDLE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= state_next;
    end

    // Next-state: accept in IDLE, WIDTH steps in CALC, one sign-fix cycle
    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_CALC;
            DIV_CALC: if (cnt == LAST_STEP) state_next = DIV_FIX;
            DIV_FIX:  state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, sign reapplication and result hold
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            rem         <= '0;
            dvd         <= '0;
            divisor     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                DIV_IDLE: if (start) begin
                    dvd     <= a_mag;
                    divisor <= b_mag;
                    sign_q  <= A[WIDTH-1] ^ B[WIDTH-1];
                    sign_r  <= A[WIDTH-1];
                    dz      <= (B == '0);
                    rem     <= '0;
                    cnt     <= '0;
                end
                DIV_CALC: begin
                    rem <= step_rem;
                    dvd <= {dvd[WIDTH-2:0], step_q};
                    cnt <= cnt + 1'b1;
                end
                DIV_FIX: begin
                    // With a zero divisor every trial succeeds, so rem ends
                    // holding |A| and the sign fix restores R = A; only Q
                    // needs forcing to -1.
                    Q           <= dz ? '1 : (sign_q ? (~dvd + 1'b1) : dvd);
                    R           <= sign_r ? (~rem + 1'b1) : rem;
                    div_by_zero <= dz;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed self-checking bench for seq_signed_divider
module tb_seq_signed_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Q;
    logic [31:0] R;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    int lat;
    logic saw_done;

    seq_signed_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .Q           (Q),
        .R           (R),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after the accept edge
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = 32'hDEAD_BEEF; B = 32'h0BAD_F00D;
    endtask

    // Count negedges until done, bounded
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        @(negedge clk); @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_Q", Q, 32'd0);
        check("rst_R", R, 32'd0);
        check("rst_dz", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100 / 7
        issue(32'd100, 32'd7);
        check("p_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("p_lat", lat, 32'd33);
        check("p_Q", Q, 32'd14);
        check("p_R", R, 32'd2);
        check("p_dz", {31'd0, div_by_zero}, 32'd0);
        check("p_busy_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("p_done_1cyc", {31'd0, done}, 32'd0);
        @(negedge clk); @(negedge clk);
        check("p_hold_Q", Q, 32'd14);

        // -100 / 7
        issue(32'hFFFF_FF9C, 32'd7);
        wait_done(lat);
        check("nd_lat", lat, 32'd33);
        check("nd_Q", Q, 32'hFFFF_FFF2);
        check("nd_R", R, 32'hFFFF_FFFE);
        @(negedge clk);

        // 100 / -7
        issue(32'd100, 32'hFFFF_FFF9);
        wait_done(lat);
        check("nv_Q", Q, 32'hFFFF_FFF2);
        check("nv_R", R, 32'd2);
        @(negedge clk);

        // 5 / 0
        issue(32'd5, 32'd0);
        wait_done(lat);
        check("z_lat", lat, 32'd33);
        check("z_Q", Q, 32'hFFFF_FFFF);
        check("z_R", R, 32'd5);
        check("z_dz", {31'd0, div_by_zero}, 32'd1);
        @(negedge clk);

        // -6 / 0: R keeps the negative dividend
        issue(32'hFFFF_FFFA, 32'd0);
        wait_done(lat);
        check("zn_Q", Q, 32'hFFFF_FFFF);
        check("zn_R", R, 32'hFFFF_FFFA);
        check("zn_dz", {31'd0, div_by_zero}, 32'd1);
        @(negedge clk);

        // most-negative / -1 wraps
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        check("mn_lat", lat, 32'd33);
        check("mn_Q", Q, 32'h8000_0000);
        check("mn_R", R, 32'd0);
        check("mn_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);

        // 9 / 3 with an ignored start at cycle 10
        issue(32'd9, 32'd3);
        repeat (9) @(negedge clk);
        start = 1'b1; A = 32'd1; B = 32'd1;
        @(negedge clk);
        start = 1'b0;
        lat = 10;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        check("ig_lat", lat, 32'd33);
        check("ig_Q", Q, 32'd3);
        check("ig_R", R, 32'd0);

        // start in the done cycle: 7 / 2
        issue(32'd7, 32'd2);
        check("b2b_done_low", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat);
        check("b2b_lat", lat, 32'd33);
        check("b2b_Q", Q, 32'd3);
        check("b2b_R", R, 32'd1);
        @(negedge clk);

        // reset mid-operation
        issue(32'd100, 32'd7);
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("ra_busy", {31'd0, busy}, 32'd0);
        check("ra_Q", Q, 32'd0);
        check("ra_R", R, 32'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("ra_no_done", {31'd0, saw_done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
